// File: rtl/cyclic_decoder_systematic_pkg.sv
// Shared constants, FSM state type and GF(2) helper for the (15,11) cyclic
// Hamming code with g(x) = x^4 + x + 1.
package cyclic_code_pkg;

  localparam int unsigned N = 15;
  localparam int unsigned K = 11;
  localparam int unsigned R = 4;
  localparam logic [R-1:0] GEN = 4'b0011;

  typedef enum logic {
    RECV,
    CORR
  } state_t;

  // x^k mod g(x), used at elaboration to derive the error-trap pattern.
  function automatic logic [R-1:0] xpow_mod_g(input int unsigned k,
                                               input logic [R-1:0] gen = GEN);
    logic [R-1:0] r;
    r = {{(R-1){1'b0}}, 1'b1};
    for (int unsigned i = 0; i < k; i++) begin
      r = {r[R-2:0], 1'b0} ^ (r[R-1] ? gen : '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/cyclic_decoder_systematic_if.sv
// Serial receive/decode channel: codeword bits in, corrected info bits out.
interface cyclic_decoder_systematic_if;
  logic enable;
  logic in;
  logic out;
  logic out_valid;
  logic err;

  modport master (output enable, output in,
                  input  out, input out_valid, input err);
  modport slave  (input  enable, input in,
                  output out, output out_valid, output err);
endinterface

// File: rtl/cyclic_decoder_systematic_syndrome.sv
// Syndrome LFSR dividing the incoming polynomial by g(x); trap zeroes it once
// the correctable error has been removed.
module cyclic_syndrome_lfsr #(
  parameter int unsigned   R   = cyclic_code_pkg::R,
  parameter logic [R-1:0]  GEN = cyclic_code_pkg::GEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic         shift_in,
  input  logic         data_in,
  input  logic         trap,
  output logic [R-1:0] s
);

  logic [R-1:0] s_q;
  logic [R-1:0] s_d;
  logic [R-1:0] base;

  always_comb begin
    s_d  = s_q;
    base = clear ? '0 : s_q;
    if (enable) begin
      if (trap) begin
        s_d = '0;
      end else if (shift_in) begin
        s_d = {base[R-2:0], data_in} ^ (base[R-1] ? GEN : '0);
      end else if (clear) begin
        s_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign s = s_q;

endmodule

// File: rtl/cyclic_decoder_systematic.sv
// Serial Meggitt decoder for the systematic (15,11) cyclic Hamming code:
// 15 receive cycles, then 11 correction cycles emitting info bits MSB-first.
module cyclic_decoder_systematic
  import cyclic_code_pkg::*;
#(
  parameter int unsigned  N   = cyclic_code_pkg::N,
  parameter int unsigned  K   = cyclic_code_pkg::K,
  parameter int unsigned  R   = cyclic_code_pkg::R,
  parameter logic [R-1:0] GEN = cyclic_code_pkg::GEN
) (
  input logic                        clk,
  input logic                        reset,
  cyclic_decoder_systematic_if.slave bus
);

  localparam int unsigned  CW      = $clog2(N);
  localparam logic [R-1:0] ERR_PAT = xpow_mod_g(N - 1, GEN);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   cw_buf_q, cw_buf_d;
  logic           out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic           err_q, err_d;

  logic [R-1:0]   syn;
  logic [R-1:0]   syn_step;
  logic           match;
  logic           lfsr_clear;
  logic           lfsr_data;

  cyclic_syndrome_lfsr #(
    .R   (R),
    .GEN (GEN)
  ) u_syndrome (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .clear    (lfsr_clear),
    .shift_in (1'b1),
    .data_in  (lfsr_data),
    .trap     (match),
    .s        (syn)
  );

  // Syndrome after the last received bit, needed the same edge it is latched.
  assign syn_step = {syn[R-2:0], bus.in} ^ (syn[R-1] ? GEN : '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cw_buf_d    = cw_buf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    match       = (state_q == CORR) && (syn == ERR_PAT);
    lfsr_clear  = (state_q == RECV) && (cnt_q == '0);
    lfsr_data   = (state_q == RECV) ? bus.in : 1'b0;

    if (bus.enable) begin
      case (state_q)
        RECV: begin
          cw_buf_d = {cw_buf_q[N-2:0], bus.in};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            out_d       = 1'b0;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
          end
          if (cnt_q == CW'(N - 1)) begin
            state_d = CORR;
            cnt_d   = '0;
            err_d   = (syn_step != '0);
          end
        end
        CORR: begin
          out_d       = cw_buf_q[N-1] ^ match;
          out_valid_d = 1'b1;
          cw_buf_d    = {cw_buf_q[N-2:0], 1'b0};
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CW'(K - 1)) begin
            state_d = RECV;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RECV;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RECV;
      cnt_q       <= '0;
      cw_buf_q    <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cw_buf_q    <= cw_buf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cyclic_decoder_systematic.sv
// Scoreboard bench: the driver queues expected 11-bit bursts, the monitor
// collects out bits on enabled edges and compares them when a burst completes.
module tb_cyclic_decoder_systematic;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cyclic_decoder_systematic_if bus ();

  cyclic_decoder_systematic #(
    .N   (15),
    .K   (11),
    .R   (4),
    .GEN (4'b0011)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [10:0] info;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  task automatic drive(logic rst, logic en, logic b);
    @(negedge clk);
    reset      = rst;
    bus.enable = en;
    bus.in     = b;
  endtask

  // rp/cp: insert a 3-cycle pause before receive bit rp / a 2-cycle pause
  // before correction step cp (negative = no pause).
  task automatic send_word(logic [14:0] cw, logic [10:0] info, logic e,
                           int rp = -1, int cp = -1);
    exp_t x;
    x.info = info;
    x.err  = e;
    exp_q.push_back(x);
    for (int i = 0; i < 15; i++) begin
      if (i == rp) repeat (3) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      drive(1'b0, 1'b1, cw[14-i]);
    end
    for (int i = 0; i < 11; i++) begin
      if (i == cp) repeat (2) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    end
  endtask

  // Monitor
  initial begin
    int          run;
    logic [10:0] got;
    logic        en_s;
    logic        rst_s;
    exp_t        e;
    run = 0;
    got = '0;
    forever begin
      @(posedge clk);
      en_s  = bus.enable;
      rst_s = reset;
      #1;
      if (rst_s) begin
        chk("reset_outputs", {29'd0, bus.out, bus.out_valid, bus.err}, 32'd0);
        run = 0;
      end else if (en_s) begin
        if (bus.out_valid) begin
          run++;
          got = {got[9:0], bus.out};
          if (run == 11) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_burst", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("info_bits", {21'd0, got}, {21'd0, e.info});
              chk("err_flag", {31'd0, bus.err}, {31'd0, e.err});
            end
          end else if (run > 11) begin
            chk("valid_length", run, 11);
          end
        end else begin
          if (run != 0 && run < 11) chk("burst_truncated", run, 11);
          run = 0;
        end
      end
    end
  end

  localparam logic [14:0] CW_CLEAN = 15'b100000000001001;
  localparam logic [10:0] INFO_1   = 11'b10000000000;

  initial begin
    logic [14:0] partial;
    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.in     = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);

    send_word(CW_CLEAN,               INFO_1, 1'b0);
    send_word(15'b000000000001001,    INFO_1, 1'b1);
    send_word(15'b100000000011001,    INFO_1, 1'b1);
    send_word(15'b100000000001000,    INFO_1, 1'b0 ^ 1'b1);
    send_word(15'b100001000001001,    INFO_1, 1'b1);
    send_word(15'b000010000000000,    11'b00000000000, 1'b1);
    send_word(15'b000000000001001,    INFO_1, 1'b1, 5, 4);

    // Partial word cut short by reset, then an all-zero word.
    partial = CW_CLEAN;
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, partial[14-i]);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    send_word(15'b000000000000000,    11'b00000000000, 1'b0);

    send_word(CW_CLEAN,               INFO_1, 1'b0);
    send_word(15'b100000000011001,    INFO_1, 1'b1);

    repeat (3) drive(1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
